// File: rtl/manual_clock_gen.sv
// ----------------------------------------------------------------------------
// manual_clock_gen
//
// Front-panel clock and reset conditioner for a hand-stepped CPU. It runs on
// the board clock and turns raw push-button and switch levels into:
//   * single-step CPU clock pulses of a fixed width (one per button press),
//   * a CPU reset that is stretched past the release of the reset button,
//   * optionally, a continuous slow CPU clock (free-run mode).
//
// Optional feature macro: MCLK_AUTO_RUN_EN
//   Defined     -> RunSw selects free-run. The FSM gains the RUN_HI/RUN_LO
//                  states and produces a CpuClk with HalfPeriod-cycle phases.
//   Not defined -> single-step only. RunSw is ignored.
//
// Parameters
//   CntWidth      width of the debounce, pulse and divider counters; every
//                 count parameter must be below 2**CntWidth
//   DebounceCount consecutive stable cycles needed to accept an input change
//   PulseWidth    cycles CpuClk stays high per step, then low for as many
//   ResetHold     cycles CpuReset stays high after reset-button release (>= 1)
//   HalfPeriod    cycles per CpuClk phase in free-run mode
//
// Ports
//   Clk        in   board clock, all logic on the rising edge
//   Reset      in   synchronous, active-low block reset
//   StepBtn    in   raw step button, asynchronous, active-high
//   ResetBtn   in   raw CPU-reset button, asynchronous, active-high
//   RunSw      in   raw run/step selector, high = free-run
//   CpuClk     out  registered clock to the CPU
//   CpuReset   out  registered, active-high reset to the CPU
//   StepCount  out  number of CpuClk rising edges issued, wraps 255 -> 0
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// mclk_debounce
//
// Two-flop synchronizer followed by a level debouncer. The debounced level
// follows the synchronized input only after the two have disagreed for
// DebounceCount consecutive cycles. A single matching cycle restarts the
// count, so bounce shorter than DebounceCount cycles never gets through.
//
// Ports
//   Clk    in   clock
//   Reset  in   synchronous, active-low reset
//   raw    in   asynchronous raw input
//   level  out  debounced level, registered
// ----------------------------------------------------------------------------
module mclk_debounce #(
  parameter int CntWidth      = 16,
  parameter int DebounceCount = 48000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level
);

  localparam logic [CntWidth-1:0] DEB_LAST = CntWidth'(DebounceCount - 1);

  logic                sync_meta;
  logic                sync;
  logic [CntWidth-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop in this
      // block samples the values from before the edge; with blocking '=' the
      // synchronizer would collapse into a single flop.
      sync_meta <= raw;
      sync      <= sync_meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// ----------------------------------------------------------------------------
// manual_clock_gen (top)
// ----------------------------------------------------------------------------
module manual_clock_gen #(
  parameter int CntWidth      = 16,
  parameter int DebounceCount = 48000,
  parameter int PulseWidth    = 8,
  parameter int ResetHold     = 16,
  parameter int HalfPeriod    = 8000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       StepBtn,
  input  logic       ResetBtn,
  input  logic       RunSw,
  output logic       CpuClk,
  output logic       CpuReset,
  output logic [7:0] StepCount
);

  localparam logic [CntWidth-1:0] PULSE_LAST = CntWidth'(PulseWidth - 1);
  localparam logic [CntWidth-1:0] HOLD_LAST  = CntWidth'(ResetHold - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HIGH   = 3'd1,
    S_LOW    = 3'd2
`ifdef MCLK_AUTO_RUN_EN
    ,
    S_RUN_HI = 3'd3,
    S_RUN_LO = 3'd4
`endif
  } state_e;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic step_deb;
  logic step_deb_d;
  logic step_edge;
  logic rst_deb;
  logic rst_deb_d;

  mclk_debounce #(
    .CntWidth      (CntWidth),
    .DebounceCount (DebounceCount)
  ) u_step_deb (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (StepBtn),
    .level (step_deb)
  );

  mclk_debounce #(
    .CntWidth      (CntWidth),
    .DebounceCount (DebounceCount)
  ) u_rst_deb (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (ResetBtn),
    .level (rst_deb)
  );

`ifdef MCLK_AUTO_RUN_EN
  localparam logic [CntWidth-1:0] HALF_LAST = CntWidth'(HalfPeriod - 1);

  logic run_deb;

  mclk_debounce #(
    .CntWidth      (CntWidth),
    .DebounceCount (DebounceCount)
  ) u_run_deb (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (RunSw),
    .level (run_deb)
  );
`else
  // Single-step build: the run selector and its divider are not used.
  logic unused_run_sw;
  assign unused_run_sw = RunSw;
  localparam int unused_half_period = HalfPeriod;
`endif

  // Registered rising edge of the debounced step button: a one-cycle pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      step_deb_d <= 1'b0;
      step_edge  <= 1'b0;
    end else begin
      step_deb_d <= step_deb;
      step_edge  <= step_deb & ~step_deb_d;
    end
  end

  // --------------------------------------------------------------------------
  // CPU reset stretcher
  //
  // CpuReset follows the debounced button high. The hold counter only starts
  // on a debounced falling edge, so after a block reset CpuReset stays high
  // until the operator has pressed and released the reset button once.
  // A re-press while holding cancels the hold; the next release restarts it.
  // --------------------------------------------------------------------------
  logic                holding;
  logic [CntWidth-1:0] hold_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      CpuReset  <= 1'b1;
      rst_deb_d <= 1'b0;
      holding   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      rst_deb_d <= rst_deb;
      if (rst_deb) begin
        CpuReset <= 1'b1;
        holding  <= 1'b0;
        hold_cnt <= '0;
      end else if (rst_deb_d) begin
        // First cycle after release: start counting the hold window.
        holding  <= 1'b1;
        hold_cnt <= '0;
      end else if (holding) begin
        if (hold_cnt == HOLD_LAST) begin
          CpuReset <= 1'b0;
          holding  <= 1'b0;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Clock FSM
  //
  // CpuClk is a flop loaded from the next state, so it changes on the same
  // edge as the state register and never glitches.
  // --------------------------------------------------------------------------
  state_e              state;
  state_e              state_next;
  logic [CntWidth-1:0] phase_cnt;
  logic [CntWidth-1:0] phase_cnt_next;
  logic                cpu_clk_next;
  logic                enter_high;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would make it hold its value and infer a latch.
    state_next     = state;
    phase_cnt_next = phase_cnt;
    cpu_clk_next   = 1'b0;
    enter_high     = 1'b0;

    case (state)
      S_IDLE: begin
        // New pulses only start while the CPU is out of reset.
        if (step_edge && !CpuReset) begin
          state_next     = S_HIGH;
          phase_cnt_next = '0;
        end
`ifdef MCLK_AUTO_RUN_EN
        // Free-run takes precedence over a coincident step edge.
        if (run_deb && !CpuReset) begin
          state_next     = S_RUN_HI;
          phase_cnt_next = '0;
        end
`endif
      end

      // Step edges seen in HIGH or LOW are simply dropped.
      S_HIGH: begin
        if (phase_cnt == PULSE_LAST) begin
          state_next     = S_LOW;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 1'b1;
        end
      end

      S_LOW: begin
        if (phase_cnt == PULSE_LAST) begin
          state_next     = S_IDLE;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 1'b1;
        end
      end

`ifdef MCLK_AUTO_RUN_EN
      // A phase always runs to completion; stopping is decided only at the
      // end of a phase, so the CPU never sees a truncated high time.
      S_RUN_HI: begin
        if (phase_cnt == HALF_LAST) begin
          state_next     = (run_deb && !CpuReset) ? S_RUN_LO : S_IDLE;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 1'b1;
        end
      end

      S_RUN_LO: begin
        if (phase_cnt == HALF_LAST) begin
          state_next     = (run_deb && !CpuReset) ? S_RUN_HI : S_IDLE;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 1'b1;
        end
      end
`endif

      default: begin
        state_next     = S_IDLE;
        phase_cnt_next = '0;
      end
    endcase

    if (state_next == S_HIGH) begin
      cpu_clk_next = 1'b1;
      enter_high   = (state != S_HIGH);
    end
`ifdef MCLK_AUTO_RUN_EN
    if (state_next == S_RUN_HI) begin
      cpu_clk_next = 1'b1;
      enter_high   = (state != S_RUN_HI);
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      CpuClk    <= 1'b0;
      StepCount <= 8'd0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_cnt_next;
      CpuClk    <= cpu_clk_next;
      // Counts CpuClk rising edges; CpuReset deliberately leaves it alone.
      if (enter_high) begin
        StepCount <= StepCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_manual_clock_gen.sv
// ----------------------------------------------------------------------------
// tb_manual_clock_gen
//
// Directed bench for manual_clock_gen with short counts (DebounceCount=4,
// PulseWidth=2, ResetHold=3, HalfPeriod=3). Stimulus pushes the expected
// CpuClk / CpuReset transitions (cycle number and StepCount) into a queue;
// an independent monitor pops one entry for each transition the DUT makes.
// ----------------------------------------------------------------------------
module tb_manual_clock_gen;

  localparam int DEB = 4;
  localparam int PW  = 2;
  localparam int RH  = 3;
  localparam int HP  = 3;

  // Latencies from a raw change driven at the negedge after posedge k.
  localparam int STEP_LAT  = DEB + 4;  // CpuClk rise
  localparam int RST_LAT   = DEB + 3;  // CpuReset rise
  localparam int REL_LAT   = DEB + 2 + RH + 1;  // CpuReset fall after release
  localparam int RUN_LAT   = DEB + 3;  // first free-run CpuClk rise

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b0;
  logic       StepBtn  = 1'b0;
  logic       ResetBtn = 1'b0;
  logic       RunSw    = 1'b0;
  logic       CpuClk;
  logic       CpuReset;
  logic [7:0] StepCount;

  manual_clock_gen #(
    .CntWidth      (16),
    .DebounceCount (DEB),
    .PulseWidth    (PW),
    .ResetHold     (RH),
    .HalfPeriod    (HP)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .StepBtn   (StepBtn),
    .ResetBtn  (ResetBtn),
    .RunSw     (RunSw),
    .CpuClk    (CpuClk),
    .CpuReset  (CpuReset),
    .StepCount (StepCount)
  );

  always #5 Clk = ~Clk;

  // cyc == number of rising edges so far.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int {EV_CLK_RISE, EV_CLK_FALL, EV_RST_RISE, EV_RST_FALL} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cycle;
    logic [7:0] count;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_count = 8'd0;
  logic       mon_en    = 1'b0;
  logic       prev_clk;
  logic       prev_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_e k, input int c, input logic [7:0] cnt);
    ev_t e;
    e.kind  = k;
    e.cycle = c;
    e.count = cnt;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected no event", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.cycle);
      check("event_step_count", StepCount, e.count);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge Clk) begin
    #1;
    if (mon_en) begin
      if (CpuClk !== prev_clk)   observe(CpuClk   ? EV_CLK_RISE : EV_CLK_FALL);
      if (CpuReset !== prev_rst) observe(CpuReset ? EV_RST_RISE : EV_RST_FALL);
    end
    prev_clk = CpuClk;
    prev_rst = CpuReset;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Wait (bounded) until every expected event has been seen.
  task automatic drain(input string name, input int budget);
    int waited = 0;
    while (exp_q.size() != 0 && waited < budget) begin
      tick(1);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d events still pending after %0d cycles, expected 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Press the step button (caller is at a negedge with StepBtn low and
  // debounced low) and expect one full pulse.
  task automatic step_press();
    int k;
    StepBtn = 1'b1;
    k = cyc;
    exp_count = exp_count + 8'd1;
    push(EV_CLK_RISE, k + STEP_LAT, exp_count);
    push(EV_CLK_FALL, k + STEP_LAT + PW, exp_count);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish by time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    int m;
    int n_wrap;

    // Block reset for two edges.
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
    tick(1);
    mon_en = 1'b1;
    check("reset_cpu_clk", CpuClk, 1'b0);
    check("reset_cpu_reset", CpuReset, 1'b1);
    check("reset_step_count", StepCount, 8'd0);
    tick(10);
    check("idle_cpu_reset", CpuReset, 1'b1);

    // One-cycle bounce on ResetBtn: nothing may change.
    ResetBtn = 1'b1;
    tick(1);
    ResetBtn = 1'b0;
    tick(15);
    check("bounce_cpu_reset", CpuReset, 1'b1);

    // Real press/release: CpuReset falls RH+1 cycles after the debounced fall.
    ResetBtn = 1'b1;
    tick(10);
    ResetBtn = 1'b0;
    m = cyc;
    push(EV_RST_FALL, m + REL_LAT, exp_count);
    drain("reset_release", 30);
    check("released_cpu_reset", CpuReset, 1'b0);
    tick(2);

    // Clean step press, held high: exactly one pulse.
    step_press();
    drain("first_step", 30);
    tick(15);
    check("first_step_count", StepCount, 8'd1);
    StepBtn = 1'b0;
    tick(10);

    // Bouncy press: toggle every 2 cycles, then settle high.
    for (int i = 0; i < 5; i++) begin
      StepBtn = 1'b1;
      tick(2);
      StepBtn = 1'b0;
      tick(2);
    end
    step_press();
    drain("bouncy_step", 30);
    tick(10);
    check("bouncy_step_count", StepCount, 8'd2);
    StepBtn = 1'b0;
    tick(10);

    // Step until the counter wraps to zero.
    n_wrap = 256 - int'(exp_count);
    for (int i = 0; i < n_wrap; i++) begin
      step_press();
      drain("wrap_step", 30);
      StepBtn = 1'b0;
      tick(10);
    end
    check("wrap_step_count", StepCount, 8'd0);

    // CpuReset rises in the middle of a high phase: pulse still completes.
    StepBtn = 1'b1;
    k = cyc;
    exp_count = exp_count + 8'd1;
    push(EV_CLK_RISE, k + STEP_LAT, exp_count);
    push(EV_RST_RISE, k + 2 + RST_LAT, exp_count);
    push(EV_CLK_FALL, k + STEP_LAT + PW, exp_count);
    tick(2);
    ResetBtn = 1'b1;
    tick(10);
    StepBtn = 1'b0;
    tick(4);
    // Release reset and press step together; the step edge lands while
    // CpuReset is still being held and must be dropped.
    ResetBtn = 1'b0;
    StepBtn  = 1'b1;
    push(EV_RST_FALL, k + 16 + REL_LAT, exp_count);
    drain("reset_mid_high", 40);
    check("reset_mid_high_clk", CpuClk, 1'b0);
    tick(15);
    check("held_step_count", StepCount, exp_count);
    StepBtn = 1'b0;
    tick(10);

    // Stepping works again once reset is gone.
    step_press();
    drain("post_reset_step", 30);
    check("post_reset_step_count", StepCount, 8'd2);
    StepBtn = 1'b0;
    tick(10);

`ifdef MCLK_AUTO_RUN_EN
    // Free-run: 3 high / 3 low; stop requested mid RUN_HI.
    k = cyc;
    RunSw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_count = exp_count + 8'd1;
      push(EV_CLK_RISE, k + RUN_LAT + 2 * HP * i, exp_count);
      push(EV_CLK_FALL, k + RUN_LAT + 2 * HP * i + HP, exp_count);
    end
    tick(14);
    RunSw = 1'b0;
    drain("free_run", 40);
    tick(15);
    check("free_run_stopped_clk", CpuClk, 1'b0);
    check("free_run_step_count", StepCount, exp_count);
`endif

    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/manual_clock_gen.md
# manual_clock_gen

Front-panel clock and reset conditioner that sits directly upstream of the CPU and drives its Clk and Reset inputs. It runs from the 16 MHz board clock and takes raw push-button/switch levels from the I/O pins. It produces clean, debounced, single-step CPU clock pulses of fixed width and a stretched CPU reset. An optional free-run mode derives a continuous slow CPU clock instead of single steps.

## Interface
- DebounceCount, 48000, consecutive stable Clk cycles required to accept an input change (3 ms at 16 MHz)
- CntWidth, 16, width of debounce, pulse and divider counters; all count parameters must be < 2^CntWidth
- PulseWidth, 8, Clk cycles CpuClk is held high per step, then held low for the same count
- ResetHold, 16, Clk cycles CpuReset stays asserted after the reset button is released
- HalfPeriod, 8000, Clk cycles per CpuClk half-period in free-run (1 kHz)
- Clk  input  1  16 MHz board clock; all logic on rising edge
- Reset  input  1  synchronous, active-low block reset
- StepBtn  input  1  raw step button, asynchronous, active-high
- ResetBtn  input  1  raw CPU-reset button, asynchronous, active-high
- RunSw  input  1  raw run/step selector, asynchronous, high = free-run (used only with MCLK_AUTO_RUN_EN)
- CpuClk  output  1  registered clock to CPU Clk
- CpuReset  output  1  registered, active-high reset to CPU Reset
- StepCount  output  8  number of CpuClk rising edges issued, wraps 255→0

## Operation
- Reset low: all state cleared; CpuClk=0, CpuReset=1, StepCount=0, debounced levels=0, FSM=IDLE, all counters 0.
- Each raw input: 2-flop synchronizer, then debouncer. Debounced level updates when synchronized value differs from it for DebounceCount consecutive cycles; the counter clears on any cycle where they match.
- Step edge = debounced StepBtn 0→1, registered one cycle.
- FSM states: IDLE, HIGH, LOW, RUN_HI, RUN_LO.
- IDLE: CpuClk=0. A step edge with CpuReset=0 moves to HIGH and loads the counter.
- HIGH: CpuClk=1 for PulseWidth cycles, then LOW. StepCount increments on entry.
- LOW: CpuClk=0 for PulseWidth cycles, then IDLE. Step edges arriving in HIGH or LOW are discarded, not queued.
- CpuReset: set while debounced ResetBtn=1. On release, stays 1 for exactly ResetHold further cycles, then 0. A re-press during hold restarts the hold.
- CpuReset=1 while in HIGH: the pulse completes normally (HIGH→LOW→IDLE). No new pulse starts while CpuReset=1.
- StepCount is not cleared by CpuReset, only by Reset.

## Timing
- Raw StepBtn rise, bounce-free → CpuClk rises exactly DebounceCount+4 Clk cycles later. Breakdown: 2 sync, DebounceCount debounce, 1 edge register, 1 output register.
- CpuClk high exactly PulseWidth cycles, low at least PulseWidth cycles. Minimum step period is 2×PulseWidth.
- Raw ResetBtn rise → CpuReset=1 after DebounceCount+3 cycles.
- Debounced ResetBtn fall → CpuReset=0 after ResetHold+1 cycles.
- Bounce shorter than DebounceCount cycles never changes a debounced level.
- Outputs are glitch-free (direct flop outputs).

## Configuration
- MCLK_AUTO_RUN_EN defined: in IDLE with debounced RunSw=1 and CpuReset=0, FSM enters RUN_HI.
  - RUN_HI: CpuClk=1 for HalfPeriod cycles; StepCount increments on entry.
  - RUN_LO: CpuClk=0 for HalfPeriod cycles.
  - RUN_HI/RUN_LO alternate while RunSw=1.
  - RunSw→0 or CpuReset→1: the current phase finishes, then the FSM goes to IDLE with CpuClk=0. No truncated high pulse.
  - Step edges are ignored in RUN states.
- Not defined: RunSw is unused, RUN_HI/RUN_LO do not exist, and the block is single-step only.

## Test plan
Bench parameters: DebounceCount=4, PulseWidth=2, ResetHold=3, HalfPeriod=3.
- Reset low 2 cycles then high, no input → CpuClk=0, CpuReset=1, StepCount=0 until ResetBtn activity. Then a 1-cycle ResetBtn press (bounce) → CpuReset stays 1 and no CpuReset rise is re-triggered.
- ResetBtn press 10 cycles then release → CpuReset=0 exactly ResetHold+1=4 cycles after the debounced fall.
- Clean StepBtn press → CpuClk rises 8 cycles after the raw edge, high 2 cycles, StepCount=1. A second press during HIGH produces no extra pulse.
- StepBtn toggling every 2 cycles for 20 cycles, then stable high → exactly one pulse, following the last toggle.
- 256 step presses → StepCount wraps to 0. CpuReset assertion mid-HIGH → pulse completes, and a subsequent press during reset hold yields no pulse.
- With MCLK_AUTO_RUN_EN: RunSw=1 → CpuClk period 6 cycles, 50% duty. RunSw=0 mid-RUN_HI → high phase completes (3 cycles), then CpuClk stays 0.
